// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard sequencer: stall/flush/freeze controls for IF/ID and ID/EX.
// Optional hazard-stall counter port stall_cycles is built only with `define STALL_CNT_EN.
package id_hazard_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HOLD} state_e;

  typedef struct packed {
    logic       is_load;
    logic       is_jalr;
    logic       use_rs1;
    logic       use_rs2;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } dec_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
endpackage

// Per-instruction field decode used for the ID, EX and MEM slots.
module id_hazard_dec
  import id_hazard_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);
  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = inst_i[6:0];
  assign unused_bits = ^{inst_i[31:25], inst_i[14:12]};

  always_comb begin
    dec_o         = '0;
    dec_o.rd      = inst_i[11:7];
    dec_o.rs1     = inst_i[19:15];
    dec_o.rs2     = inst_i[24:20];
    // rd!=0 on loads is what keeps x0 from ever producing a hazard
    dec_o.is_load = (opc == OPC_LOAD) && (inst_i[11:7] != 5'd0);
    dec_o.is_jalr = (opc == OPC_JALR);
    dec_o.use_rs1 = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    dec_o.use_rs2 = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
  end
endmodule

module id_hazard_ctrl
  import id_hazard_pkg::*;
#(
  parameter int RST_FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic [31:0] ex_inst,
  input  logic [31:0] mem_inst,
  input  logic        ex_redirect,
  input  logic        dmem_busy,
  output logic        if_stall,
  output logic        id_stall,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        back_stall
`ifdef STALL_CNT_EN
  , output logic [31:0] stall_cycles
`endif
);
  localparam int CW = 3;

  logic [2:0][31:0] insts;
  dec_t [2:0]       dec;      // [0]=ID, [1]=EX, [2]=MEM
  logic             jalr_ex, jalr_mem, ld_use;
  logic [1:0]       n_stall;
  logic             hz_stall;
  logic             unused_dec;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign insts = {mem_inst, ex_inst, id_inst};

  for (genvar g = 0; g < 3; g++) begin : g_dec
    id_hazard_dec u_dec (.inst_i(insts[g]), .dec_o(dec[g]));
  end

  assign unused_dec = ^{dec[0].is_load, dec[0].rd,
                        dec[1].is_jalr, dec[1].use_rs1, dec[1].use_rs2, dec[1].rs1, dec[1].rs2,
                        dec[2].is_jalr, dec[2].use_rs1, dec[2].use_rs2, dec[2].rs1, dec[2].rs2};

  // JALR resolves its target in ID, so load data cannot be forwarded to it
  assign jalr_ex  = dec[0].is_jalr && dec[1].is_load && (dec[1].rd == dec[0].rs1);
  assign jalr_mem = dec[0].is_jalr && dec[2].is_load && (dec[2].rd == dec[0].rs1);
  assign ld_use   = dec[1].is_load &&
                    ((dec[0].use_rs1 && (dec[1].rd == dec[0].rs1)) ||
                     (dec[0].use_rs2 && (dec[1].rd == dec[0].rs2)));

  always_comb begin
    n_stall = 2'd0;
    if (jalr_ex)                 n_stall = 2'd2;
    else if (jalr_mem || ld_use) n_stall = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= CW'(RST_FLUSH_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // a busy data memory freezes everything, including a pending redirect
    if (!dmem_busy) begin
      case (state_q)
        ST_INIT: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_RUN;
        end
        ST_HOLD: begin
          if (ex_redirect || (cnt_q == CW'(1))) state_d = ST_RUN;
          else                                  cnt_d   = cnt_q - CW'(1);
        end
        ST_RUN: begin
          if (!ex_redirect && (n_stall == 2'd2)) begin
            state_d = ST_HOLD;
            cnt_d   = CW'(1);
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_comb begin
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    back_stall = 1'b0;
    hz_stall   = 1'b0;
    if (!rst_n) begin
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else if (dmem_busy) begin
      if_stall   = 1'b1;
      id_stall   = 1'b1;
      back_stall = 1'b1;
    end else if (ex_redirect) begin
      id_flush = 1'b1;
      ex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end
        ST_HOLD: begin
          if_stall = 1'b1;
          ex_flush = 1'b1;
          hz_stall = 1'b1;
        end
        ST_RUN: begin
          if (n_stall != 2'd0) begin
            if_stall = 1'b1;
            ex_flush = 1'b1;
            hz_stall = 1'b1;
          end
        end
        default: begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_cnt_q <= '0;
    else if (hz_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cycles = stall_cnt_q;
`else
  logic unused_hz;
  assign unused_hz = hz_stall;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed vector table, reset corner sequence, and
// randomized traffic against a cycle-level reference model.
module tb_id_hazard_ctrl;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] LW_X5   = 32'h0000A283;  // lw x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003;  // lw x0,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] JALR_X5 = 32'h00028067;  // jalr x0,0(x5)
  localparam logic [31:0] LUI_X5  = 32'h000282B7;  // lui x5 with rs1 field = 5
  localparam logic [31:0] SW_X5   = 32'h00512023;  // sw x5,0(x2)

  // {if_stall, id_stall, id_flush, ex_flush, back_stall}
  localparam logic [4:0] O_ZERO = 5'b00000;
  localparam logic [4:0] O_FL   = 5'b00110;
  localparam logic [4:0] O_HZ   = 5'b10010;
  localparam logic [4:0] O_BZ   = 5'b11001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = NOP, ex_inst = NOP, mem_inst = NOP;
  logic        ex_redirect = 1'b0, dmem_busy = 1'b0;
  logic        if_stall, id_stall, id_flush, ex_flush, back_stall;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  id_hazard_ctrl #(.RST_FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .ex_inst(ex_inst), .mem_inst(mem_inst),
    .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
    .if_stall(if_stall), .id_stall(id_stall), .id_flush(id_flush), .ex_flush(ex_flush),
    .back_stall(back_stall)
`ifdef STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] id, ex, mem;
    logic        r, b;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[$];

  // reference model state: remaining init-flush cycles, remaining forced stalls, stall count
  int      m_init, m_hold;
  longint  m_cnt;

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {if_stall, id_stall, id_flush, ex_flush, back_stall};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {if,ids,idf,exf,back}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                     input logic r, input logic b, input logic [4:0] exp);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.r = r; v.b = b; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                       input logic r, input logic b);
    id_inst = id; ex_inst = ex; mem_inst = mem; ex_redirect = r; dmem_busy = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hazard_n(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem);
    logic [6:0] op;
    logic       ex_ld, mem_ld, u1, u2;
    op     = id[6:0];
    ex_ld  = (ex[6:0] == 7'b0000011) && (ex[11:7] != 0);
    mem_ld = (mem[6:0] == 7'b0000011) && (mem[11:7] != 0);
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
    if (op == 7'b1100111 && ex_ld && ex[11:7] == id[19:15]) return 2;
    if (op == 7'b1100111 && mem_ld && mem[11:7] == id[19:15]) return 1;
    if (ex_ld && ((u1 && ex[11:7] == id[19:15]) || (u2 && ex[11:7] == id[24:20]))) return 1;
    return 0;
  endfunction

  // one clock of the model: returns expected outputs, advances to the next cycle
  task automatic model_step(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                            input logic r, input logic b, output logic [4:0] exp);
    int n;
    if (b) exp = O_BZ;
    else if (r) begin
      exp = O_FL;
      if (m_init > 0) m_init--;
      m_hold = 0;
    end else if (m_init > 0) begin
      exp = O_FL;
      m_init--;
    end else if (m_hold > 0) begin
      exp = O_HZ;
      m_hold--;
      m_cnt++;
    end else begin
      n = hazard_n(id, ex, mem);
      exp = (n > 0) ? O_HZ : O_ZERO;
      if (n > 0) begin
        m_cnt++;
        m_hold = n - 1;
      end
    end
  endtask

  function automatic logic [31:0] rnd_inst(input bit load_bias);
    logic [31:0] i;
    logic [6:0]  op;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: op = 7'b0000011; 1: op = 7'b0110011; 2: op = 7'b0010011; 3: op = 7'b0100011;
      4: op = 7'b1100011; 5: op = 7'b0110111; 6: op = 7'b0010111; 7: op = 7'b1101111;
      8: op = 7'b1100111; default: op = 7'b1110011;
    endcase
    if (load_bias && $urandom_range(0, 1) == 0) op = 7'b0000011;
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  initial begin
    logic [4:0] exp;
    logic [31:0] ri, re, rm;
    logic rr, rb;

    // directed sequence, starting in the first cycle after reset release
    add(NOP,     NOP,    NOP,   0, 0, O_FL);    // 0 init
    add(NOP,     NOP,    NOP,   0, 0, O_FL);    // 1 init
    add(NOP,     NOP,    NOP,   0, 0, O_ZERO);  // 2 run
    add(ADD_X6,  LW_X5,  NOP,   0, 0, O_HZ);    // 3 load-use
    add(ADD_X6,  NOP,    LW_X5, 0, 0, O_ZERO);  // 4 add advances
    add(JALR_X5, LW_X5,  NOP,   0, 0, O_HZ);    // 5 jalr, load in EX
    add(JALR_X5, NOP,    LW_X5, 0, 0, O_HZ);    // 6 hold cycle
    add(JALR_X5, NOP,    NOP,   0, 0, O_ZERO);  // 7
    add(JALR_X5, NOP,    LW_X5, 0, 0, O_HZ);    // 8 jalr, load in MEM
    add(JALR_X5, NOP,    NOP,   0, 0, O_ZERO);  // 9
    add(LUI_X5,  LW_X5,  NOP,   0, 0, O_ZERO);  // 10 lui ignores rs1
    add(ADD_X6,  LW_X0,  NOP,   0, 0, O_ZERO);  // 11 x0 load
    add(SW_X5,   LW_X5,  NOP,   0, 0, O_HZ);    // 12 rs2 match
    add(SW_X5,   NOP,    LW_X5, 0, 0, O_ZERO);  // 13
    add(JALR_X5, LW_X5,  NOP,   0, 0, O_HZ);    // 14 enter hold
    add(JALR_X5, NOP,    LW_X5, 1, 0, O_FL);    // 15 redirect aborts hold
    add(NOP,     NOP,    NOP,   0, 0, O_ZERO);  // 16 back in run
    add(JALR_X5, LW_X5,  NOP,   0, 0, O_HZ);    // 17 enter hold
    add(JALR_X5, NOP,    LW_X5, 1, 1, O_BZ);    // 18 busy freezes
    add(JALR_X5, NOP,    LW_X5, 1, 1, O_BZ);    // 19
    add(JALR_X5, NOP,    LW_X5, 1, 1, O_BZ);    // 20
    add(JALR_X5, NOP,    LW_X5, 1, 0, O_FL);    // 21 redirect honored
    add(NOP,     NOP,    NOP,   0, 0, O_ZERO);  // 22 run, not hold
    add(ADD_X6,  LW_X5,  NOP,   1, 0, O_FL);    // 23 redirect over hazard
    add(ADD_X6,  LW_X5,  NOP,   0, 1, O_BZ);    // 24 busy over hazard
    add(NOP,     NOP,    NOP,   0, 0, O_ZERO);  // 25

    // reset state with hostile inputs
    apply(JALR_X5, LW_X5, LW_X5, 1, 1);
    tick(); tick();
    @(negedge clk);
    check("reset_outputs", O_FL);
`ifdef STALL_CNT_EN
    check32("reset_stall_cycles", stall_cycles, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      apply(tbl[k].id, tbl[k].ex, tbl[k].mem, tbl[k].r, tbl[k].b);
      @(negedge clk);
      check($sformatf("tbl[%0d]", k), tbl[k].exp);
      tick();
    end
`ifdef STALL_CNT_EN
    check32("tbl_stall_cycles", stall_cycles, 32'd7);
`endif

    // async reset in the middle of HOLD
    apply(JALR_X5, LW_X5, NOP, 0, 0);
    @(negedge clk);
    check("midhold_enter", O_HZ);
    tick();
    apply(JALR_X5, NOP, LW_X5, 0, 1);
    #1 check("midhold_busy", O_BZ);
    rst_n = 1'b0;
    #1 check("midhold_async_rst", O_FL);
`ifdef STALL_CNT_EN
    check32("midhold_stall_cycles", stall_cycles, 32'd0);
`endif
    tick();
    apply(NOP, NOP, NOP, 0, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rerelease[%0d]", c), (c < 2) ? O_FL : O_ZERO);
      tick();
    end

    // randomized traffic against the model, from a fresh reset
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
    m_init = 2; m_hold = 0; m_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      ri = rnd_inst(1'b0);
      re = rnd_inst(1'b1);
      rm = rnd_inst(1'b1);
      if ($urandom_range(0, 3) == 0) ri[6:0] = 7'b1100111;
      rr = ($urandom_range(0, 99) < 12);
      rb = ($urandom_range(0, 99) < 18);
      apply(ri, re, rm, rr, rb);
      model_step(ri, re, rm, rr, rb, exp);
      @(negedge clk);
      check($sformatf("rand[%0d]", c), exp);
      tick();
    end
`ifdef STALL_CNT_EN
    check32("rand_stall_cycles", stall_cycles, 32'(m_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Sequences the decode stage: generates stall, flush and freeze controls for the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, including JALR targets resolved in ID that cannot use forwarded load data.
- Applies EX-stage redirect flushes, a post-reset fetch flush, and whole-pipeline freeze while data memory is busy.
- Sits beside the ID stage. Its outputs drive the IF PC enable, the ID register write enable/reset and the EX/MEM/WB enables.

Parameters:
- RST_FLUSH_CYCLES, 2: cycles after reset release during which IF/ID and ID/EX are held flushed. Legal range 1..7.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_inst  in  32  instruction currently in ID
- ex_inst  in  32  instruction in EX
- mem_inst  in  32  instruction in MEM
- ex_redirect  in  1  EX resolved mispredict or taken redirect
- dmem_busy  in  1  data memory multi-cycle access in progress
- if_stall  out  1  hold PC and fetch
- id_stall  out  1  deassert the ID pipeline-register write enable (hold ID/EX contents)
- id_flush  out  1  reset the IF/ID instruction to NOP
- ex_flush  out  1  reset ID/EX to a bubble (NOP)
- back_stall  out  1  freeze EX/MEM/WB registers
- stall_cycles  out  32  hazard stall count; present only with STALL_CNT_EN

Behaviour:
- Reset is asynchronous and active-low on rst_n. Asserting rst_n low at any time, including mid-HOLD, forces state INIT, count=RST_FLUSH_CYCLES and stall_cycles=0.
- While rst_n is low: id_flush=1, ex_flush=1, if_stall=0, id_stall=0, back_stall=0.
- Outputs are combinational from state and inputs (Mealy), so a hazard takes effect in the cycle it is detected.
- States:
  - INIT: id_flush=ex_flush=1. Count decrements each cycle. At count==1 the next state is RUN.
  - RUN: hazard detection is active.
  - HOLD: if_stall=1, id_flush=0, ex_flush=1. The cycle with count==1 is the last stall cycle; the next state is RUN. No new detection happens in HOLD.
- Field rules, with rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0]:
  - Load: opcode 0000011 and rd!=0.
  - Uses rs1: every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - Uses rs2: BRANCH 1100011, STORE 0100011 and OP 0110011.
  - JALR: opcode 1100111.
- RUN detection. Let N be the number of stall cycles:
  - ID is JALR and ex_inst is a load with rd==rs1: N=2.
  - Else ID is JALR and mem_inst is a load with rd==rs1: N=1.
  - Else ex_inst is a load and rd matches a used rs1 or rs2 of id_inst: N=1.
  - Else N=0.
- If N>0: if_stall=id_stall... specifically if_stall=1 and ex_flush=1 (bubble into EX) in the detecting cycle. If N==2 the next state is HOLD with count=1; otherwise the state stays RUN and re-evaluates.
- Priority, highest first:
  1. rst_n.
  2. dmem_busy: if_stall=id_stall=back_stall=1, both flushes 0, state and count hold, ex_redirect is ignored. The producer holds ex_redirect because EX is frozen.
  3. ex_redirect: id_flush=ex_flush=1, if_stall=0. HOLD aborts to RUN. INIT still completes.
  4. INIT.
  5. HOLD.
  6. RUN detection.
- id_stall is asserted only under dmem_busy. A hazard is handled by holding IF/ID (if_stall, no id_flush) and bubbling ID/EX.
- x0 never creates a hazard.

Optional Feature:
- STALL_CNT_EN defined:
  - stall_cycles increments on each rising edge where the state is RUN or HOLD, a hazard stall is active and dmem_busy=0.
  - Redirect and INIT cycles are excluded.
  - The count saturates at 0xFFFFFFFF and resets to 0.
- Undefined: the port, the counter and its logic are absent.

Test Plan:
- Reset release with RST_FLUSH_CYCLES=2 -> id_flush=ex_flush=1 for exactly 2 cycles after rst_n rises, then all outputs 0 with NOP traffic.
- EX=lw x5,0(x1), ID=add x6,x5,x7 -> one cycle of if_stall=1 and ex_flush=1. The next cycle all outputs are 0 and the add advances. stall_cycles=1 when STALL_CNT_EN is defined.
- EX=lw x5, ID=jalr x0,0(x5) -> if_stall=1 and ex_flush=1 for 2 consecutive cycles, then 0. With the load in MEM instead of EX -> exactly 1 stall cycle.
- EX=lw x0 or lw x5 with ID=lui x5 -> no stall. EX=lw x5 with ID=sw x5,0(x2) (rs2 match) -> 1 stall cycle.
- HOLD (JALR case, cycle 2) with ex_redirect=1 -> id_flush=ex_flush=1, if_stall=0, and RUN on the next cycle.
- dmem_busy=1 for 3 cycles during a JALR HOLD with ex_redirect=1 -> if_stall=id_stall=back_stall=1 for 3 cycles, state frozen, redirect honored on the first cycle with dmem_busy=0. rst_n pulsed low mid-HOLD -> immediate INIT outputs.
